// File: rtl/muldiv_sequencer_if.sv
// Request/response handshake bundle for the iterative multiply/divide sequencer.
// master: the requester (execute stage); slave: the sequencer itself.
interface muldiv_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            start_valid;
    logic            start_ready;
    logic [1:0]      start_op;
    logic [XLEN-1:0] start_rs1;
    logic [XLEN-1:0] start_rs2;
    logic            result_valid;
    logic            result_ready;
    logic [XLEN-1:0] result_data;

    modport master (
        output start_valid, start_op, start_rs1, start_rs2, result_ready,
        input  start_ready, result_valid, result_data
    );

    modport slave (
        input  start_valid, start_op, start_rs1, start_rs2, result_ready,
        output start_ready, result_valid, result_data
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU controller that borrows the core's shared ALU.
// One ALU add (shift-add multiply) or subtract (restoring divide) per cycle for ITERS cycles.
// Divide by zero bypasses the iterations. Optional build macro MULDIV_FAST_ZERO_EN also
// bypasses the iterations for MUL/MULHU with a zero operand.
module muldiv_sequencer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ITERS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    muldiv_sequencer_if.slave    bus,
    output logic                 alu_busy_o,
    output logic [XLEN-1:0]      alu_a_o,
    output logic [XLEN-1:0]      alu_b_o,
    output logic [4:0]           alu_op_o,
    input  logic [XLEN-1:0]      alu_result_i
);

    localparam int unsigned CntW = $clog2(ITERS);
    localparam logic [CntW-1:0] CntLast = CntW'(ITERS - 1);

    localparam logic [1:0] OpMul   = 2'b00;
    localparam logic [1:0] OpMulhu = 2'b01;
    localparam logic [1:0] OpDivu  = 2'b10;
    localparam logic [1:0] OpRemu  = 2'b11;

    localparam logic [4:0] AluAdd = 5'b00000;
    localparam logic [4:0] AluSub = 5'b00001;

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

    state_e          state_q;
    logic [1:0]      op_q;
    logic [XLEN-1:0] opnd_q;   // M for multiply, D for divide
    logic [XLEN-1:0] hi_q;     // Phi for multiply, R for divide
    logic [XLEN-1:0] lo_q;     // Plo for multiply, Q for divide
    logic [XLEN-1:0] res_q;
    logic [CntW-1:0] cnt_q;

    logic            is_div;
    logic            carry;
    logic            ge;
    logic            fast_zero;
    logic [XLEN-1:0] hi_d;
    logic [XLEN-1:0] lo_d;
    logic [XLEN-1:0] res_d;

    assign is_div = op_q[1];

    // ALU drive and the per-iteration next values of the partial product / remainder.
    always_comb begin
        alu_a_o  = '0;
        alu_b_o  = '0;
        alu_op_o = AluAdd;
        if (state_q == StIter) begin
            if (is_div) begin
                alu_a_o  = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
                alu_b_o  = opnd_q;
                alu_op_o = AluSub;
            end else begin
                alu_a_o  = hi_q;
                alu_b_o  = lo_q[0] ? opnd_q : '0;
                alu_op_o = AluAdd;
            end
        end

        // Carry/borrow come from local compares, never from the ALU.
        carry = (alu_result_i < alu_b_o);
        // A set R[31] means the shifted remainder exceeds XLEN bits, so it must be >= D.
        ge    = hi_q[XLEN-1] | !(alu_a_o < opnd_q);

        if (is_div) begin
            hi_d = ge ? alu_result_i : alu_a_o;
            lo_d = {lo_q[XLEN-2:0], ge};
        end else begin
            hi_d = {carry, alu_result_i[XLEN-1:1]};
            lo_d = {alu_result_i[0], lo_q[XLEN-1:1]};
        end

        unique case (op_q)
            OpMul:   res_d = lo_d;
            OpMulhu: res_d = hi_d;
            OpDivu:  res_d = lo_d;
            OpRemu:  res_d = hi_d;
            default: res_d = '0;
        endcase
    end

    // Multiply-by-zero shortcut, only in builds that enable it.
    always_comb begin
`ifdef MULDIV_FAST_ZERO_EN
        fast_zero = !bus.start_op[1] && ((bus.start_rs1 == '0) || (bus.start_rs2 == '0));
`else
        fast_zero = 1'b0;
`endif
    end

    // Control FSM plus iteration datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= OpMul;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start_valid) begin
                        op_q  <= bus.start_op;
                        cnt_q <= '0;
                        hi_q  <= '0;
                        if (bus.start_op[1]) begin
                            opnd_q <= bus.start_rs2;
                            lo_q   <= bus.start_rs1;
                            if (bus.start_rs2 == '0) begin
                                res_q   <= (bus.start_op == OpDivu) ? '1 : bus.start_rs1;
                                state_q <= StDone;
                            end else begin
                                state_q <= StIter;
                            end
                        end else begin
                            opnd_q <= bus.start_rs1;
                            lo_q   <= bus.start_rs2;
                            if (fast_zero) begin
                                res_q   <= '0;
                                state_q <= StDone;
                            end else begin
                                state_q <= StIter;
                            end
                        end
                    end
                end
                StIter: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        res_q   <= res_d;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (bus.result_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.start_ready  = (state_q == StIdle);
    assign bus.result_valid = (state_q == StDone);
    assign bus.result_data  = res_q;
    assign alu_busy_o       = (state_q == StIter);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed, table-driven bench for muldiv_sequencer with a behavioural ADD/SUB ALU.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_busy;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_op;
    logic [31:0] alu_result;

    int n_total = 0;
    int n_pass  = 0;

    muldiv_sequencer_if bus ();

    muldiv_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .alu_busy_o   (alu_busy),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_op_o     (alu_op),
        .alu_result_i (alu_result)
    );

    // Shared-ALU stand-in: only ADD and SUB matter here.
    assign alu_result = (alu_op == 5'b00001) ? (alu_a - alu_b) : (alu_a + alu_b);

    always #5 clk = ~clk;

`ifdef MULDIV_FAST_ZERO_EN
    localparam int ZeroLat  = 1;
    localparam int ZeroBusy = 0;
`else
    localparam int ZeroLat  = 33;
    localparam int ZeroBusy = 32;
`endif

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Called #1 after an edge with the DUT idle; returns #1 after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] rs1, input logic [31:0] rs2);
        bus.start_valid = 1'b1;
        bus.start_op    = op;
        bus.start_rs1   = rs1;
        bus.start_rs2   = rs2;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
    endtask

    // lat = cycle index (1 = first cycle after accept) at which result_valid is seen.
    task automatic wait_valid(output int lat, output int busy);
        lat  = 0;
        busy = 0;
        for (int k = 1; k <= 100; k++) begin
            if (bus.result_valid) begin
                lat = k;
                break;
            end
            if (alu_busy) busy++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int busy;
        logic [31:0] data;
        issue(v.op, v.rs1, v.rs2);
        wait_valid(lat, busy);
        data = bus.result_data;
        check({v.name, " data"}, data, v.exp_data);
        check({v.name, " latency"}, lat, v.exp_lat);
        check({v.name, " busy cycles"}, busy, v.exp_busy);
        @(posedge clk);
        #1;
        check({v.name, " idle after"}, {31'd0, bus.start_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        int busy;
        int valid_seen;

        bus.start_valid  = 1'b0;
        bus.start_op     = 2'b00;
        bus.start_rs1    = '0;
        bus.start_rs2    = '0;
        bus.result_ready = 1'b1;

        vecs.push_back('{"mul 7*6",        2'b00, 32'd7,        32'd6,        32'd42,       33, 32});
        vecs.push_back('{"mulhu ff*ff",    2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 32});
        vecs.push_back('{"mul ff*ff",      2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33, 32});
        vecs.push_back('{"mulhu 2^16^2",   2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 33, 32});
        vecs.push_back('{"mul 2^16^2",     2'b00, 32'h00010000, 32'h00010000, 32'h00000000, 33, 32});
        vecs.push_back('{"divu 100/7",     2'b10, 32'd100,      32'd7,        32'd14,       33, 32});
        vecs.push_back('{"remu 100/7",     2'b11, 32'd100,      32'd7,        32'd2,        33, 32});
        vecs.push_back('{"divu ff/1",      2'b10, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33, 32});
        vecs.push_back('{"divu 2^31/3",    2'b10, 32'h80000000, 32'd3,        32'h2AAAAAAA, 33, 32});
        vecs.push_back('{"remu 2^31/3",    2'b11, 32'h80000000, 32'd3,        32'd2,        33, 32});
        vecs.push_back('{"divu ff/fe",     2'b10, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        33, 32});
        vecs.push_back('{"remu ff/fe",     2'b11, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        33, 32});
        vecs.push_back('{"remu ff/8..1",   2'b11, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 33, 32});
        vecs.push_back('{"divu 1/ff",      2'b10, 32'd1,        32'hFFFFFFFF, 32'd0,        33, 32});
        vecs.push_back('{"divu 5/0",       2'b10, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  0});
        vecs.push_back('{"remu 5/0",       2'b11, 32'd5,        32'd0,        32'd5,        1,  0});
        vecs.push_back('{"mul 0*1234",     2'b00, 32'd0,        32'd1234,     32'd0, ZeroLat, ZeroBusy});
        vecs.push_back('{"mulhu 99*0",     2'b01, 32'd99,       32'd0,        32'd0, ZeroLat, ZeroBusy});

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset start_ready",  {31'd0, bus.start_ready},  32'd1);
        check("reset alu_busy",     {31'd0, alu_busy},         32'd0);
        check("reset result_valid", {31'd0, bus.result_valid}, 32'd0);
        check("reset result_data",  bus.result_data,           32'd0);
        check("reset alu_a",        alu_a,                     32'd0);
        check("reset alu_b",        alu_b,                     32'd0);
        check("reset alu_op",       {27'd0, alu_op},           32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: result held while a competing start is ignored.
        bus.result_ready = 1'b0;
        issue(2'b00, 32'd7, 32'd6);
        wait_valid(lat, busy);
        check("bp latency", lat, 33);
        bus.start_valid = 1'b1;
        bus.start_op    = 2'b10;
        bus.start_rs1   = 32'd9;
        bus.start_rs2   = 32'd3;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp result_data", bus.result_data, 32'd42);
            check("bp start_ready", {31'd0, bus.start_ready}, 32'd0);
            check("bp result_valid", {31'd0, bus.result_valid}, 32'd1);
        end
        bus.start_valid  = 1'b0;
        bus.result_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release valid", {31'd0, bus.result_valid}, 32'd0);
        check("bp release ready", {31'd0, bus.start_ready}, 32'd1);
        check("bp release busy", {31'd0, alu_busy}, 32'd0);

        // Reset in the middle of a divide.
        issue(2'b10, 32'd1000, 32'd3);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        check("mid busy before rst", {31'd0, alu_busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst start_ready", {31'd0, bus.start_ready}, 32'd1);
        check("rst alu_busy", {31'd0, alu_busy}, 32'd0);
        check("rst result_valid", {31'd0, bus.result_valid}, 32'd0);
        valid_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.result_valid) valid_seen++;
            @(posedge clk);
            #1;
        end
        check("rst no result", valid_seen, 0);
        run_vec('{"mul 3*3", 2'b00, 32'd3, 32'd3, 32'd9, 33, 32});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
